wb_arbiter_2m: RTL and testbench

// Two-master round-robin arbiter for one pipelined Wishbone B4 slave (wb_slave_memory).

---
 rtl/wb_arb_pkg.sv | 11 +
 rtl/wb_arb_watchdog.sv | 29 ++
 rtl/wb_arbiter_2m.sv | 129 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;

  localparam int unsigned ARB_MAX_OUT = 4;
  localparam int unsigned ARB_TIMEOUT = 256;
  localparam int unsigned OUT_W       = $clog2(ARB_MAX_OUT + 1);
  localparam int unsigned WDOG_W      = $clog2(ARB_TIMEOUT);

endpackage

// File: rtl/wb_arb_watchdog.sv
// Cycle counter that pulses expire_c when a stalled response window reaches TIMEOUT-1.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT,
  parameter int unsigned W       = WDOG_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_c = en_i & ~clr_i & (cnt_q == W'(TIMEOUT - 1));
    cnt_d    = cnt_q;
    if (clr_i || expire_c) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin arbiter for a pipelined Wishbone B4 slave; grant held per cyc,
// outstanding-request limiting and a watchdog that turns a hung slave into an err.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUT    = ARB_MAX_OUT,
  parameter int unsigned TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    m_cyc_i,
  input  logic [1:0]                    m_stb_i,
  input  logic [1:0]                    m_we_i,
  input  logic [2*ADDR_WIDTH-1:0]       m_adr_i,
  input  logic [2*DATA_WIDTH-1:0]       m_dat_i,
  input  logic [2*(DATA_WIDTH/8)-1:0]   m_sel_i,
  output logic [DATA_WIDTH-1:0]         m_dat_o,
  output logic [1:0]                    m_ack_o,
  output logic [1:0]                    m_err_o,
  output logic [1:0]                    m_stall_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_WIDTH-1:0]         s_adr_o,
  output logic [DATA_WIDTH-1:0]         s_dat_o,
  output logic [DATA_WIDTH/8-1:0]       s_sel_o,
  input  logic [DATA_WIDTH-1:0]         s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_stall_i
);

  localparam int unsigned SEL_W  = DATA_WIDTH / 8;
  localparam int unsigned OUT_CW = (MAX_OUT == ARB_MAX_OUT) ? OUT_W : $clog2(MAX_OUT + 1);
  localparam int unsigned WD_CW  = (TIMEOUT == ARB_TIMEOUT) ? WDOG_W : $clog2(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [OUT_CW-1:0] out_q, out_d;

  logic gnt, idx, active, out_full, resp_ok, inc, dec, wd_en, wd_clr, wd_expire;

  // Grant qualifiers shared by the datapath mux and the counters.
  always_comb begin
    gnt      = (state_q != ARB_IDLE);
    idx      = (state_q == ARB_GNT1);
    active   = gnt & m_cyc_i[idx];
    out_full = (out_q == OUT_CW'(MAX_OUT));
    resp_ok  = active & (out_q != '0);
    inc      = s_stb_o & ~s_stall_i;
    dec      = resp_ok & (s_ack_i | s_err_i);
    wd_en    = resp_ok & ~s_ack_i & ~s_err_i;
    wd_clr   = ~active | s_ack_i | s_err_i;
  end

  // Route the granted master to the slave; the loser sees a permanent stall.
  always_comb begin
    m_dat_o   = s_dat_i;
    s_cyc_o   = active;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    m_stall_o = 2'b11;
    if (gnt) begin
      s_stb_o        = active & m_stb_i[idx] & ~out_full;
      s_we_o         = m_we_i[idx];
      s_adr_o        = idx ? m_adr_i[ADDR_WIDTH +: ADDR_WIDTH] : m_adr_i[0 +: ADDR_WIDTH];
      s_dat_o        = idx ? m_dat_i[DATA_WIDTH +: DATA_WIDTH] : m_dat_i[0 +: DATA_WIDTH];
      s_sel_o        = idx ? m_sel_i[SEL_W +: SEL_W] : m_sel_i[0 +: SEL_W];
      m_stall_o[idx] = s_stall_i | out_full;
      m_ack_o[idx]   = resp_ok & s_ack_i;
      m_err_o[idx]   = (resp_ok & s_err_i) | wd_expire;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (&m_cyc_i)       state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        else if (m_cyc_i[0]) state_d = ARB_GNT0;
        else if (m_cyc_i[1]) state_d = ARB_GNT1;
      end
      ARB_GNT0, ARB_GNT1: begin
        if (!m_cyc_i[idx]) begin
          state_d = ARB_IDLE;
          last_d  = idx;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Dropping cyc or a watchdog expiry forgets every outstanding request.
    if (!active || wd_expire) out_d = '0;
    else if (inc && !dec)     out_d = out_q + OUT_CW'(1);
    else if (dec && !inc)     out_d = out_q - OUT_CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .W       (WD_CW)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_c (wd_expire)
  );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: pipelined slave model, round-robin reference, memory scoreboard.
module tb_wb_arbiter_2m;

  localparam int unsigned AW = 32, DW = 32, SW = 4, MAXO = 4, TMO = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [2*AW-1:0] m_adr_i;
  logic [2*DW-1:0] m_dat_i;
  logic [2*SW-1:0] m_sel_i;
  logic [DW-1:0] m_dat_o;
  logic [1:0]    m_ack_o, m_err_o, m_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i, s_stall_i;

  int checks = 0;
  int errors = 0;
  int exp_last;
  bit stray;
  logic [31:0] ref_mem [8];

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MAXO), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  // Pipelined slave memory: acks in order, at least one cycle after acceptance.
  logic        slv_hold = 1'b0, slv_force_ack = 1'b0, slv_rand_stall = 1'b0;
  logic [31:0] slv_mem [256];
  logic [31:0] pend [$];
  assign s_err_i = 1'b0;

  always @(posedge clk) begin
    s_ack_i <= slv_force_ack || (!slv_hold && pend.size() > 0);
    if (!slv_force_ack && !slv_hold && pend.size() > 0) s_dat_i <= pend.pop_front();
    s_stall_i <= slv_rand_stall && ($urandom_range(0, 3) == 0);
    if (s_cyc_o && s_stb_o && !s_stall_i) begin
      if (s_we_o) slv_mem[s_adr_o[9:2]] <= s_dat_o;
      pend.push_back(s_we_o ? 32'h0 : slv_mem[s_adr_o[9:2]]);
    end
    if (!s_cyc_o) pend.delete();
  end

  // Reference round-robin: contention goes to the master that did not own the bus last.
  function automatic int rr_pick(input bit r0, input bit r1);
    if (r0 && r1) return 1 - exp_last;
    return r0 ? 0 : 1;
  endfunction

  function automatic logic [31:0] marker(input int n);
    return 32'h1000_0000 * 32'(n + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int n);
    m_cyc_i[n] = 1'b1;
    m_adr_i[n*AW +: AW] = marker(n);
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    exp_last = 1;
  endtask

  task automatic m_xfer(input int n, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        output logic [31:0] rd, output bit ok);
    int cnt;
    ok = 1'b0;
    rd = '0;
    m_stb_i[n] = 1'b1;
    m_we_i[n] = we;
    m_adr_i[n*AW +: AW] = adr;
    m_dat_i[n*DW +: DW] = dat;
    m_sel_i[n*SW +: SW] = 4'hF;
    cnt = 0;
    @(negedge clk);
    while (m_stall_o[n]) begin
      if (m_ack_o[1-n] || m_err_o[1-n]) stray = 1'b1;
      cnt++;
      if (cnt > 64) begin m_stb_i[n] = 1'b0; return; end
      @(negedge clk);
    end
    tick();
    m_stb_i[n] = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (m_ack_o[1-n] || m_err_o[1-n]) stray = 1'b1;
      if (m_ack_o[n]) begin rd = m_dat_o; ok = 1'b1; return; end
      cnt++;
      if (cnt > 64) return;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); end
    checks++; if (m_stall_o !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b want 11", m_stall_o); end
    checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got %b/%b want 00/00", m_ack_o, m_err_o); end
    checks++; if (s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0 || s_we_o !== 1'b0) begin errors++; $display("FAIL reset_sbus: adr %h dat %h sel %h we %b want zeros", s_adr_o, s_dat_o, s_sel_o, s_we_o); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    bit ok;
    stray = 1'b0;
    tick();
    req(0);
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0 || m_stall_o[0] !== 1'b1) begin errors++; $display("FAIL wr_arb_latency: s_cyc %b stall0 %b want 0 1", s_cyc_o, m_stall_o[0]); end
    tick();
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== marker(0)) begin errors++; $display("FAIL wr_grant0: s_cyc %b adr %h want 1 %h", s_cyc_o, s_adr_o, marker(0)); end
    tick();
    m_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_write_ack: got none want ack"); end
    tick();
    m_xfer(0, 1'b0, 32'h10, 32'h0, rd, ok);
    checks++; if (!ok || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_read_data: ok %0d got %h want DEADBEEF", ok, rd); end
    checks++; if (stray) begin errors++; $display("FAIL wr_m1_quiet: got ack/err on m1 want none"); end
    tick();
    m_cyc_i[0] = 1'b0;
    exp_last = 0;
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL wr_release_cyc: got %b want 0", s_cyc_o); end
    tick();
    tick();
  endtask

  task automatic test_arbitration();
    int win, lose;
    bit hold;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      req(0);
      req(1);
      win  = rr_pick(1'b1, 1'b1);
      lose = 1 - win;
      hold = (r % 2 == 1);
      @(negedge clk);
      checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL arb_idle r%0d: cyc %b stall %b want 0 11", r, s_cyc_o, m_stall_o); end
      tick();
      @(negedge clk);
      checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== marker(win) || m_stall_o[lose] !== 1'b1) begin errors++; $display("FAIL arb_grant r%0d: cyc %b adr %h loser_stall %b want 1 %h 1", r, s_cyc_o, s_adr_o, m_stall_o[lose], marker(win)); end
      tick();
      m_cyc_i[win] = 1'b0;
      if (!hold) m_cyc_i[lose] = 1'b0;
      exp_last = win;
      @(negedge clk);
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL arb_drop r%0d: cyc %b want 0", r, s_cyc_o); end
      tick();
      @(negedge clk);
      checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL arb_gap r%0d: cyc %b stall %b want 0 11", r, s_cyc_o, m_stall_o); end
      if (hold) begin
        tick();
        @(negedge clk);
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== marker(lose)) begin errors++; $display("FAIL arb_handover r%0d: cyc %b adr %h want 1 %h", r, s_cyc_o, s_adr_o, marker(lose)); end
        tick();
        m_cyc_i[lose] = 1'b0;
        exp_last = lose;
      end
      tick();
      tick();
    end
  endtask

  task automatic test_outstanding();
    int out_m, max_m, sent, acks, full_cyc;
    bit acc, ack;
    slv_hold = 1'b1;
    req(0);
    tick();
    tick();
    m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0; m_adr_i[0 +: AW] = 32'h20; m_sel_i[0 +: SW] = 4'hF;
    out_m = 0; max_m = 0; sent = 0; acks = 0; full_cyc = 0;
    for (int c = 0; c < 100 && acks < 6; c++) begin
      @(negedge clk);
      checks++; if (m_stall_o[0] !== (out_m == MAXO)) begin errors++; $display("FAIL out_stall c%0d: got %b want %b (out %0d)", c, m_stall_o[0], out_m == MAXO, out_m); end
      if (out_m == MAXO) begin
        checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL out_stb_block c%0d: got %b want 0", c, s_stb_o); end
        full_cyc++;
      end
      acc = m_stb_i[0] && !m_stall_o[0];
      ack = m_ack_o[0];
      out_m += int'(acc) - int'(ack);
      sent  += int'(acc);
      acks  += int'(ack);
      if (out_m > max_m) max_m = out_m;
      if (full_cyc == 3) slv_hold = 1'b0;
      tick();
      if (sent == 6) m_stb_i[0] = 1'b0;
    end
    checks++; if (max_m != MAXO) begin errors++; $display("FAIL out_peak: got %0d want %0d", max_m, MAXO); end
    checks++; if (acks != 6 || sent != 6) begin errors++; $display("FAIL out_acks: acks %0d sent %0d want 6 6", acks, sent); end
    m_stb_i[0] = 1'b0;
    m_cyc_i[0] = 1'b0;
    exp_last = 0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int k;
    bit bad;
    slv_hold = 1'b1;
    req(0);
    tick();
    tick();
    m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0; m_adr_i[0 +: AW] = 32'h30;
    @(negedge clk);
    checks++; if (m_stall_o[0] !== 1'b0) begin errors++; $display("FAIL wd_accept: stall %b want 0", m_stall_o[0]); end
    tick();
    m_stb_i[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_err_o[0] && k < TMO + 20);
    checks++; if (k != TMO) begin errors++; $display("FAIL wd_latency: err after %0d cycles want %0d", k, TMO); end
    checks++; if (m_err_o[1] !== 1'b0 || m_ack_o !== 2'b00) begin errors++; $display("FAIL wd_other: err1 %b ack %b want 0 00", m_err_o[1], m_ack_o); end
    tick();
    @(negedge clk);
    checks++; if (m_err_o[0] !== 1'b0 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL wd_pulse_hold: err0 %b cyc %b want 0 1", m_err_o[0], s_cyc_o); end
    slv_hold = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL wd_late_ack: got ack/err after expiry want none"); end
    tick();
    m_cyc_i[0] = 1'b0;
    exp_last = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    req(0);
    tick();
    req(1);
    tick();
    m_stb_i[0] = 1'b1; m_we_i[0] = 1'b1; m_adr_i[0 +: AW] = 32'h40; m_dat_i[0 +: DW] = 32'h5555_AAAA;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    m_stb_i[0] = 1'b0;
    m_adr_i[0 +: AW] = marker(0);
    tick();
    rst_i = 1'b0;
    exp_last = 1;
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL rst_mid: cyc %b stall %b want 0 11", s_cyc_o, m_stall_o); end
    tick();
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== marker(rr_pick(1'b1, 1'b1)) || m_stall_o !== 2'b10) begin errors++; $display("FAIL rst_regrant: cyc %b adr %h stall %b want 1 %h 10", s_cyc_o, s_adr_o, m_stall_o, marker(rr_pick(1'b1, 1'b1))); end
    checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL rst_stale_ack: got %b want 00", m_ack_o); end
    tick();
    m_cyc_i = 2'b00;
    exp_last = 0;
    tick();
    tick();
  endtask

  task automatic test_drop_outstanding();
    int sent;
    slv_hold = 1'b1;
    req(0);
    tick();
    tick();
    m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0; m_adr_i[0 +: AW] = 32'h50;
    sent = 0;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      @(negedge clk);
      if (!m_stall_o[0]) sent++;
      tick();
    end
    m_stb_i[0] = 1'b0;
    m_cyc_i[0] = 1'b0;
    slv_force_ack = 1'b1;
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL drop_cyc: got %b want 0", s_cyc_o); end
    tick();
    slv_force_ack = 1'b0;
    @(negedge clk);
    checks++; if (m_ack_o !== 2'b00 || m_stall_o !== 2'b11) begin errors++; $display("FAIL drop_late_ack: ack %b stall %b want 00 11", m_ack_o, m_stall_o); end
    exp_last = 0;
    slv_hold = 1'b0;
    tick();
    tick();
  endtask

  task automatic session(input int n, input int nops);
    logic [31:0] rd, d;
    bit ok;
    int a;
    for (int i = 0; i < nops; i++) begin
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        ref_mem[a] = d;
        m_xfer(n, 1'b1, 32'(a * 4), d, rd, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_write m%0d a%0d: no ack", n, a); end
      end else begin
        m_xfer(n, 1'b0, 32'(a * 4), 32'h0, rd, ok);
        checks++; if (!ok || rd !== ref_mem[a]) begin errors++; $display("FAIL rnd_read m%0d a%0d: ok %0d got %h want %h", n, a, ok, rd, ref_mem[a]); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    bit ok, r0, r1;
    int win;
    slv_rand_stall = 1'b1;
    req(0);
    tick();
    tick();
    for (int a = 0; a < 8; a++) begin
      ref_mem[a] = $urandom;
      m_xfer(0, 1'b1, 32'(a * 4), ref_mem[a], rd, ok);
      tick();
    end
    m_cyc_i[0] = 1'b0;
    exp_last = 0;
    tick();
    tick();
    for (int r = 0; r < 20; r++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      if (r0) req(0);
      if (r1) req(1);
      win = rr_pick(r0, r1);
      tick();
      @(negedge clk);
      checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== marker(win) || (r0 && r1 && m_stall_o[1-win] !== 1'b1)) begin errors++; $display("FAIL rnd_grant r%0d: cyc %b adr %h stall %b want m%0d", r, s_cyc_o, s_adr_o, m_stall_o, win); end
      tick();
      m_cyc_i[1-win] = 1'b0;
      session(win, $urandom_range(1, 3));
      m_cyc_i[win] = 1'b0;
      exp_last = win;
      tick();
      tick();
    end
    slv_rand_stall = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    exp_last = 1;
    test_reset();
    test_write_read();
    test_arbitration();
    test_outstanding();
    test_watchdog();
    test_reset_mid();
    test_drop_outstanding();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
